bcd_conv_arbiter: RTL and testbench

- Shares one multi-cycle binary-to-BCD converter (double-dabble core, ld/done handshake) between N requesters.
- Arbitrates round-robin and latches the selected operand. Sequences the converter's load/wait protocol.
- Returns the result with the requester ID on a single valid/ready response channel.
- Has a timeout watchdog that reports a converter that never completes.

---
 rtl/bcd_conv_arbiter.sv | 247 ++++++++++++++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_conv_arbiter
//  Description : Shares one multi-cycle binary-to-BCD converter (ld/done
//                handshake) between N requesters. Requesters are served
//                round-robin. The winning operand is latched and loaded into
//                the converter. The result is returned with the requester
//                index on one valid/ready response channel. A watchdog turns
//                a converter that never finishes into an error response.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1        clock
//    rst        in   1        synchronous active-high reset
//    req_valid  in   N        request pending, one bit per requester
//    req_bin    in   N*WID    operands, requester i at [i*WID +: WID]
//    req_ready  out  N        one-hot single-cycle accept pulse
//    rsp_valid  out  1        response available
//    rsp_ready  in   1        response consumer accepts
//    rsp_id     out  IDW      requester the response belongs to
//    rsp_bcd    out  BCDWID   converted value (0 on timeout)
//    rsp_err    out  1        converter timed out
//    busy       out  1        arbiter is not idle
//    cvt_ld     out  1        converter load strobe
//    cvt_bin    out  WID      converter operand
//    cvt_bcd    in   BCDWID   converter result
//    cvt_done   in   1        converter done (high while idle)
// ============================================================================
module bcd_conv_arbiter #(
    parameter  int N      = 4,
    parameter  int WID    = 128,
    parameter  int TMO    = 1023,
    localparam int BCDWID = ((WID + (WID - 4) / 3) + 3) & -4,
    localparam int IDW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req_valid,
    input  logic [N*WID-1:0]    req_bin,
    output logic [N-1:0]        req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [BCDWID-1:0]   rsp_bcd,
    output logic                rsp_err,
    output logic                busy,
    output logic                cvt_ld,
    output logic [WID-1:0]      cvt_bin,
    input  logic [BCDWID-1:0]   cvt_bcd,
    input  logic                cvt_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_TMR_W = 16;
    localparam logic [15:0]     c_TMO   = 16'(TMO);

    localparam logic [2:0]      c_IDLE  = 3'd0;
    localparam logic [2:0]      c_LOAD  = 3'd1;
    localparam logic [2:0]      c_GUARD = 3'd2;
    localparam logic [2:0]      c_WAIT  = 3'd3;
    localparam logic [2:0]      c_RESP  = 3'd4;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]                 r_state;
    logic [IDW-1:0]             r_ptr;
    logic [c_TMR_W-1:0]         r_timer;
    logic [N-1:0]               r_req_ready;
    logic                       r_rsp_valid;
    logic [IDW-1:0]             r_rsp_id;
    logic [BCDWID-1:0]          r_rsp_bcd;
    logic                       r_rsp_err;
    logic                       r_busy;
    logic                       r_cvt_ld;
    logic [WID-1:0]             r_cvt_bin;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [2:0]                 w_state_nxt;
    logic [2*N-1:0]             w_dbl;
    logic [N-1:0]               w_rot;
    logic                       w_gnt_vld;
    logic [IDW-1:0]             w_gnt_idx;
    logic [N-1:0]               w_gnt_oh;
    logic [WID-1:0]             w_sel_bin;
    logic                       w_tmo_hit;

    logic [IDW-1:0]             w_ptr_n;
    logic [c_TMR_W-1:0]         w_timer_n;
    logic [N-1:0]               w_req_ready_n;
    logic                       w_rsp_valid_n;
    logic [IDW-1:0]             w_rsp_id_n;
    logic [BCDWID-1:0]          w_rsp_bcd_n;
    logic                       w_rsp_err_n;
    logic                       w_busy_n;
    logic                       w_cvt_ld_n;
    logic [WID-1:0]             w_cvt_bin_n;

    // ------------------------------------------------------------------------
    // Round-robin grant
    // The request vector is rotated so that bit 0 is the requester just
    // after the last winner; the lowest set bit of the rotated vector is the
    // next winner. Concatenating the vector with itself makes the rotation a
    // plain right shift by ptr+1 (a shift of N when ptr = N-1).
    // ------------------------------------------------------------------------
    assign w_dbl = {req_valid, req_valid};
    assign w_rot = N'(w_dbl >> (int'(r_ptr) + 1));

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_gnt_vld && w_rot[i]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IDW'((int'(r_ptr) + 1 + i) % N);
            end
        end
    end

    assign w_gnt_oh  = N'(1) << w_gnt_idx;
    assign w_sel_bin = WID'(req_bin >> (int'(w_gnt_idx) * WID));
    assign w_tmo_hit = (r_timer == c_TMO);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_gnt_vld) w_state_nxt = c_LOAD;
            c_LOAD:  w_state_nxt = c_GUARD;
            // cvt_done from before the load may still be high in LOAD; the
            // converter only drops it after sampling ld, so one cycle is
            // skipped before done is trusted.
            c_GUARD: w_state_nxt = c_WAIT;
            c_WAIT:  if (cvt_done || w_tmo_hit) w_state_nxt = c_RESP;
            c_RESP:  if (rsp_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: next values for the output registers
    // ------------------------------------------------------------------------
    always_comb begin
        w_ptr_n       = r_ptr;
        w_timer_n     = r_timer;
        w_req_ready_n = '0;
        w_rsp_valid_n = r_rsp_valid;
        w_rsp_id_n    = r_rsp_id;
        w_rsp_bcd_n   = r_rsp_bcd;
        w_rsp_err_n   = r_rsp_err;
        w_cvt_ld_n    = 1'b0;
        w_cvt_bin_n   = r_cvt_bin;
        w_busy_n      = (w_state_nxt != c_IDLE);
        case (r_state)
            c_IDLE: begin
                if (w_gnt_vld) begin
                    w_req_ready_n = w_gnt_oh;
                    w_ptr_n       = w_gnt_idx;
                    w_rsp_id_n    = w_gnt_idx;
                    w_cvt_bin_n   = w_sel_bin;
                    // ld is high for the whole LOAD cycle that follows
                    w_cvt_ld_n    = 1'b1;
                end
            end
            c_LOAD: begin
                w_timer_n = '0;
            end
            c_WAIT: begin
                w_timer_n = r_timer + 16'd1;
                // done wins when it arrives on the same cycle as the timeout
                if (cvt_done) begin
                    w_rsp_bcd_n   = cvt_bcd;
                    w_rsp_err_n   = 1'b0;
                    w_rsp_valid_n = 1'b1;
                end else if (w_tmo_hit) begin
                    w_rsp_bcd_n   = '0;
                    w_rsp_err_n   = 1'b1;
                    w_rsp_valid_n = 1'b1;
                end
            end
            c_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_n = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= IDW'(N - 1);
            r_timer     <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_bcd   <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_cvt_ld    <= 1'b0;
            r_cvt_bin   <= '0;
        end else begin
            r_ptr       <= w_ptr_n;
            r_timer     <= w_timer_n;
            r_req_ready <= w_req_ready_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_id    <= w_rsp_id_n;
            r_rsp_bcd   <= w_rsp_bcd_n;
            r_rsp_err   <= w_rsp_err_n;
            r_busy      <= w_busy_n;
            r_cvt_ld    <= w_cvt_ld_n;
            r_cvt_bin   <= w_cvt_bin_n;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_bcd   = r_rsp_bcd;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;
    assign cvt_ld    = r_cvt_ld;
    assign cvt_bin   = r_cvt_bin;

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_conv_arbiter
//  Description : Self-checking bench for bcd_conv_arbiter with a behavioural
//                converter whose done latency is set per job, and a
//                transaction-level reference model that predicts every output
//                cycle by cycle from grant times and fixed latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_conv_arbiter;

    localparam int N      = 4;
    localparam int WID    = 16;
    localparam int TMO    = 8;
    localparam int BCDWID = ((WID + (WID - 4) / 3) + 3) & -4;
    localparam int IDW    = 2;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N*WID-1:0]     req_bin   = '0;
    logic                 rsp_ready = 1'b1;
    logic [N-1:0]         req_ready;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [BCDWID-1:0]    rsp_bcd;
    logic                 rsp_err;
    logic                 busy;
    logic                 cvt_ld;
    logic [WID-1:0]       cvt_bin;
    logic [BCDWID-1:0]    cvt_bcd;
    logic                 cvt_done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_conv_arbiter #(.N(N), .WID(WID), .TMO(TMO)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_bin   (req_bin),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_bcd   (rsp_bcd),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .cvt_ld    (cvt_ld),
        .cvt_bin   (cvt_bin),
        .cvt_bcd   (cvt_bcd),
        .cvt_done  (cvt_done)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Decimal digits by plain division
    function automatic logic [BCDWID-1:0] to_bcd(input logic [WID-1:0] v);
        logic [BCDWID-1:0] r;
        int unsigned       x;
        r = '0;
        x = v;
        for (int d = 0; d < BCDWID / 4; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Converter stub: done rises cfg_d cycles after ld is sampled (never when
    // cfg_d = 0). With cfg_stale, done stays high one extra cycle after ld.
    // ------------------------------------------------------------------------
    int             cfg_d     = 1;
    logic           cfg_stale = 1'b0;
    int             stub_cnt;
    logic           stub_drop;
    logic [WID-1:0] stub_bin;

    always @(posedge clk) begin
        if (rst) begin
            cvt_done  <= 1'b1;
            stub_cnt  <= 0;
            stub_drop <= 1'b0;
            stub_bin  <= '0;
        end else if (cvt_ld) begin
            stub_bin  <= cvt_bin;
            stub_cnt  <= cfg_d;
            cvt_done  <= cfg_stale;
            stub_drop <= cfg_stale;
        end else begin
            if (stub_drop) begin
                cvt_done  <= 1'b0;
                stub_drop <= 1'b0;
            end
            if (stub_cnt == 1) cvt_done <= 1'b1;
            if (stub_cnt > 0)  stub_cnt <= stub_cnt - 1;
        end
    end

    assign cvt_bcd = cvt_done ? to_bcd(stub_bin) : {BCDWID{1'b1}};

    // ------------------------------------------------------------------------
    // Reference model: one job at a time; response time = grant + latency
    // ------------------------------------------------------------------------
    int                fix_d     = -1;
    logic              fix_stale = 1'b0;
    int                cyc       = 0;
    logic              m_idle    = 1'b1;
    int                m_ptr     = N - 1;
    logic              job_act   = 1'b0;
    int                job_start = 0;
    int                job_lat   = 0;
    logic              job_err   = 1'b0;
    logic [BCDWID-1:0] job_bcd   = '0;
    logic [N-1:0]      e_rdy     = '0;
    logic              e_ld      = 1'b0;
    logic              e_busy    = 1'b0;
    logic              e_rv      = 1'b0;
    logic [IDW-1:0]    e_id      = '0;
    logic [BCDWID-1:0] e_bcd     = '0;
    logic              e_err     = 1'b0;
    logic [WID-1:0]    e_bin     = '0;
    int                grant_log[$];
    logic [BCDWID-1:0] rsp_log[$];

    initial begin : mon
        int   g;
        int   d;
        logic found;
        forever begin
            @(negedge clk);
            cyc++;
            check("req_ready", 64'(req_ready), 64'(e_rdy));
            check("cvt_ld",    64'(cvt_ld),    64'(e_ld));
            check("busy",      64'(busy),      64'(e_busy));
            check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
            if (e_ld) check("cvt_bin", 64'(cvt_bin), 64'(e_bin));
            if (e_rv) begin
                check("rsp_id",  64'(rsp_id),  64'(e_id));
                check("rsp_bcd", 64'(rsp_bcd), 64'(e_bcd));
                check("rsp_err", 64'(rsp_err), 64'(e_err));
            end
            for (int k = 0; k < N; k++) if (req_ready[k]) grant_log.push_back(k);
            if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_bcd);

            // predictions for the next cycle
            e_rdy = '0;
            e_ld  = 1'b0;
            if (rst) begin
                m_idle  = 1'b1;
                m_ptr   = N - 1;
                job_act = 1'b0;
                e_rv    = 1'b0;
                e_busy  = 1'b0;
                e_id    = '0;
                e_bcd   = '0;
                e_err   = 1'b0;
            end else begin
                if (m_idle && |req_valid) begin
                    found = 1'b0;
                    g     = 0;
                    for (int k = 1; k <= N; k++) begin
                        if (!found && req_valid[(m_ptr + k) % N]) begin
                            found = 1'b1;
                            g     = (m_ptr + k) % N;
                        end
                    end
                    m_ptr    = g;
                    m_idle   = 1'b0;
                    e_rdy[g] = 1'b1;
                    e_ld     = 1'b1;
                    e_id     = IDW'(g);
                    e_bin    = req_bin[g*WID +: WID];
                    d = (fix_d >= 0) ? fix_d : int'($urandom_range(TMO + 3, 0));
                    cfg_d     = d;
                    cfg_stale = fix_stale;
                    job_act   = 1'b1;
                    job_start = cyc + 1;
                    if (d != 0 && d <= TMO + 1) begin
                        job_lat = d + 2;
                        job_err = 1'b0;
                        job_bcd = to_bcd(e_bin);
                    end else begin
                        job_lat = TMO + 3;
                        job_err = 1'b1;
                        job_bcd = '0;
                    end
                end else if (e_rv && rsp_ready) begin
                    e_rv    = 1'b0;
                    m_idle  = 1'b1;
                    job_act = 1'b0;
                end
                if (job_act && !e_rv && (cyc + 1 == job_start + job_lat)) begin
                    e_rv  = 1'b1;
                    e_bcd = job_bcd;
                    e_err = job_err;
                end
                e_busy = !m_idle;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(input int max, output int gi, output int n);
        gi = -1;
        n  = 0;
        for (int i = 0; i < max; i++) begin
            tick();
            n++;
            if (|req_ready) begin
                for (int k = 0; k < N; k++) if (req_ready[k]) gi = k;
                break;
            end
        end
        if (gi < 0) check("grant_wait_expired", 64'(0), 64'(1));
    endtask

    task automatic wait_rsp(input int max, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < max; i++) begin
            tick();
            n++;
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("rsp_wait_expired", 64'(0), 64'(1));
    endtask

    task automatic wait_idle(input int max);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("idle_wait_expired", 64'(0), 64'(1));
    endtask

    // single request: raise, take grant, drop, wait for response
    task automatic one_job(input int id, input logic [WID-1:0] op, input int d,
                           output int gi, output int nrsp);
        int n;
        fix_d = d;
        req_bin[id*WID +: WID] = op;
        req_valid[id] = 1'b1;
        wait_grant(50, gi, n);
        req_valid[id] = 1'b0;
        wait_rsp(60, nrsp);
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin : main
        int gi;
        int n;
        int nr;
        logic [19:0] fair_exp [4];

        repeat (3) tick();
        rst = 1'b0;
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_busy",      64'(busy),      64'(0));
        check("reset_cvt_bin",   64'(cvt_bin),   64'(0));

        // fairness: all four requesters continuously valid
        fix_d = 9;
        req_bin[0*WID +: WID] = 16'd0;
        req_bin[1*WID +: WID] = 16'd9;
        req_bin[2*WID +: WID] = 16'd10;
        req_bin[3*WID +: WID] = 16'd12345;
        grant_log.delete();
        rsp_log.delete();
        req_valid = '1;
        for (int i = 0; i < 300 && grant_log.size() < 5; i++) tick();
        req_valid = '0;
        wait_idle(60);
        check("fair_grant_count", 64'(grant_log.size()), 64'(5));
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check("fair_grant_order", 64'(grant_log[i]), 64'(i % N));
        fair_exp[0] = 20'h0;
        fair_exp[1] = 20'h9;
        fair_exp[2] = 20'h10;
        fair_exp[3] = 20'h12345;
        for (int i = 0; i < 4 && i < rsp_log.size(); i++)
            check("fair_rsp_bcd", 64'(rsp_log[i]), 64'(fair_exp[i]));

        // single request with all ones
        one_job(2, 16'hFFFF, 9, gi, nr);
        check("single_grant", 64'(gi), 64'(2));
        check("single_id",    64'(rsp_id),  64'(2));
        check("single_bcd",   64'(rsp_bcd), 64'(20'h65535));
        check("single_err",   64'(rsp_err), 64'(0));
        wait_idle(10);

        // backpressure: response held, another requester waits
        rsp_ready = 1'b0;
        one_job(1, 16'd4321, 5, gi, nr);
        req_bin[3*WID +: WID] = 16'd777;
        req_valid[3] = 1'b1;
        repeat (20) tick();
        check("bp_bcd_held", 64'(rsp_bcd), 64'(20'h04321));
        check("bp_busy",     64'(busy),    64'(1));
        rsp_ready = 1'b1;
        fix_d = 4;
        wait_grant(10, gi, n);
        req_valid[3] = 1'b0;
        check("bp_next_grant_id",  64'(gi), 64'(3));
        check("bp_next_grant_lag", 64'(n),  64'(2));
        wait_idle(40);

        // converter never completes
        one_job(0, 16'd1234, 0, gi, nr);
        check("tmo_err", 64'(rsp_err), 64'(1));
        check("tmo_bcd", 64'(rsp_bcd), 64'(0));
        check("tmo_lat", 64'(nr),      64'(TMO + 3));
        wait_idle(10);

        // done on the same cycle as the timeout: result wins
        one_job(1, 16'd5678, TMO + 1, gi, nr);
        check("tmo_edge_err", 64'(rsp_err), 64'(0));
        check("tmo_edge_bcd", 64'(rsp_bcd), 64'(20'h05678));
        wait_idle(10);

        // done one cycle too late
        one_job(2, 16'd42, TMO + 2, gi, nr);
        check("tmo_late_err", 64'(rsp_err), 64'(1));
        wait_idle(10);

        // stale done held across LOAD and GUARD
        fix_stale = 1'b1;
        one_job(3, 16'd999, 6, gi, nr);
        fix_stale = 1'b0;
        check("stale_lat", 64'(nr),      64'(8));
        check("stale_bcd", 64'(rsp_bcd), 64'(20'h00999));
        wait_idle(10);

        // randomized traffic
        fix_d = -1;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(3, 0) == 0) begin
                    req_valid[k] = ~req_valid[k];
                    req_bin[k*WID +: WID] = 16'($urandom);
                end
            end
            rsp_ready = ($urandom_range(3, 0) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle(60);

        // reset in the middle of WAIT
        fix_d = 0;
        req_bin[1*WID +: WID] = 16'd55;
        req_valid[1] = 1'b1;
        wait_grant(20, gi, n);
        req_valid[1] = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_req_ready", 64'(req_ready), 64'(0));
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_mid_rsp_id",    64'(rsp_id),    64'(0));
        check("rst_mid_rsp_bcd",   64'(rsp_bcd),   64'(0));
        check("rst_mid_rsp_err",   64'(rsp_err),   64'(0));
        check("rst_mid_busy",      64'(busy),      64'(0));
        check("rst_mid_cvt_ld",    64'(cvt_ld),    64'(0));
        check("rst_mid_cvt_bin",   64'(cvt_bin),   64'(0));
        fix_d = 3;
        req_bin[0*WID +: WID] = 16'd2024;
        req_valid = '1;
        wait_grant(10, gi, n);
        req_valid = '0;
        check("rst_first_grant", 64'(gi), 64'(0));
        wait_rsp(30, nr);
        check("rst_after_bcd", 64'(rsp_bcd), 64'(20'h02024));
        wait_idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
